// File: rtl/dffrs_init_seq_if.sv
// Request/response bundle between bank requesters and the DFFRS init sequencer.
// master = requester side, slave = sequencer side.
interface dffrs_init_seq_if #(
    parameter int NBANK = 4
);
    logic [NBANK-1:0] REQ;
    logic [NBANK-1:0] OP;
    logic [NBANK-1:0] RN_N;
    logic [NBANK-1:0] SN_N;
    logic [NBANK-1:0] CKEN;
    logic [NBANK-1:0] ACK;
    logic             BUSY;

    modport master (
        output REQ, OP,
        input  RN_N, SN_N, CKEN, ACK, BUSY
    );

    modport slave (
        input  REQ, OP,
        output RN_N, SN_N, CKEN, ACK, BUSY
    );
endinterface

// File: rtl/dffrs_init_seq.sv
// Round-robin sequencer issuing one glitch-free RN/SN pulse at a time to flop banks,
// followed by a clock-enable recovery window and a one-cycle ACK.
module dffrs_init_seq #(
    parameter int NBANK = 4,
    parameter int PW    = 2,
    parameter int REC   = 2
) (
    input  logic          CK,
    input  logic          RST,
    dffrs_init_seq_if.slave bus
);
    localparam int MAXC = (PW > REC) ? PW : REC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NBANK);
    localparam logic [CW-1:0] PW_LOAD  = CW'(PW - 1);
    localparam logic [CW-1:0] REC_LOAD = CW'(REC - 1);

    typedef enum logic [1:0] {IDLE, PULSE, RECOV, DONE} state_t;

    state_t           state, stateNxt;
    logic [CW-1:0]    cnt, cntNxt;
    logic [IW-1:0]    gnt, gntNxt;
    logic [IW-1:0]    ptr, ptrNxt;
    logic [NBANK-1:0] rnReg, rnNxt;
    logic [NBANK-1:0] snReg, snNxt;
    logic [NBANK-1:0] ckenReg, ckenNxt;
    logic [NBANK-1:0] ackReg, ackNxt;
    logic             busyReg, busyNxt;
    logic             found;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    cand;

    // Every output is a flop so the RN/SN pins never see decode glitches.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            gnt     <= '0;
            ptr     <= IW'(NBANK - 1);
            rnReg   <= '1;
            snReg   <= '1;
            ckenReg <= '1;
            ackReg  <= '0;
            busyReg <= 1'b0;
        end else begin
            state   <= stateNxt;
            cnt     <= cntNxt;
            gnt     <= gntNxt;
            ptr     <= ptrNxt;
            rnReg   <= rnNxt;
            snReg   <= snNxt;
            ckenReg <= ckenNxt;
            ackReg  <= ackNxt;
            busyReg <= busyNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        gntNxt   = gnt;
        ptrNxt   = ptr;
        rnNxt    = rnReg;
        snNxt    = snReg;
        ckenNxt  = ckenReg;
        ackNxt   = ackReg;
        busyNxt  = busyReg;
        found    = 1'b0;
        sel      = '0;
        cand     = '0;

        // Search starts just past the last grant, so the previous winner is checked last.
        for (int i = 1; i <= NBANK; i++) begin
            cand = IW'((int'(ptr) + i) % NBANK);
            if (!found && bus.REQ[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    gntNxt   = sel;
                    ptrNxt   = sel;
                    cntNxt   = PW_LOAD;
                    stateNxt = PULSE;
                    busyNxt  = 1'b1;
                    ckenNxt[sel] = 1'b0;
                    if (bus.OP[sel]) snNxt[sel] = 1'b0;
                    else             rnNxt[sel] = 1'b0;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    rnNxt    = '1;
                    snNxt    = '1;
                    cntNxt   = REC_LOAD;
                    stateNxt = RECOV;
                end else begin
                    cntNxt = cnt - CW'(1);
                end
            end
            RECOV: begin
                if (cnt == '0) begin
                    ckenNxt[gnt] = 1'b1;
                    ackNxt[gnt]  = 1'b1;
                    stateNxt     = DONE;
                end else begin
                    cntNxt = cnt - CW'(1);
                end
            end
            DONE: begin
                ackNxt   = '0;
                busyNxt  = 1'b0;
                stateNxt = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign bus.RN_N = rnReg;
    assign bus.SN_N = snReg;
    assign bus.CKEN = ckenReg;
    assign bus.ACK  = ackReg;
    assign bus.BUSY = busyReg;
endmodule

// File: tb/tb_dffrs_init_seq.sv
// Bench for dffrs_init_seq: three instances (PW/REC = 2/2, 1/1, 5/3) checked every cycle
// against a timeline model of grant, pulse, recovery and ACK.
module tb_dffrs_init_seq;
    localparam int NB = 4;

    logic          CK = 1'b0;
    logic          RST;
    logic [NB-1:0] reqV [3];
    logic [NB-1:0] opV  [3];

    int checks   = 0;
    int failures = 0;

    int pwA  [3] = '{2, 1, 5};
    int recA [3] = '{2, 1, 3};

    // Model: a granted sequence is described only by its start edge, bank and op.
    bit mAct   [3];
    int mBank  [3];
    bit mOp    [3];
    int mStart [3];
    int mPtr   [3];
    int edgeNo = 0;

    always #5 CK = ~CK;

    dffrs_init_seq_if #(.NBANK(NB)) ifMain ();
    dffrs_init_seq_if #(.NBANK(NB)) ifFast ();
    dffrs_init_seq_if #(.NBANK(NB)) ifSlow ();

    assign ifMain.REQ = reqV[0];
    assign ifMain.OP  = opV[0];
    assign ifFast.REQ = reqV[1];
    assign ifFast.OP  = opV[1];
    assign ifSlow.REQ = reqV[2];
    assign ifSlow.OP  = opV[2];

    dffrs_init_seq #(.NBANK(NB), .PW(2), .REC(2)) uMain (.CK(CK), .RST(RST), .bus(ifMain));
    dffrs_init_seq #(.NBANK(NB), .PW(1), .REC(1)) uFast (.CK(CK), .RST(RST), .bus(ifFast));
    dffrs_init_seq #(.NBANK(NB), .PW(5), .REC(3)) uSlow (.CK(CK), .RST(RST), .bus(ifSlow));

    // Packed view: {RN_N, SN_N, CKEN, ACK, BUSY}
    function automatic logic [16:0] actualOf(input int n);
        case (n)
            0:       return {ifMain.RN_N, ifMain.SN_N, ifMain.CKEN, ifMain.ACK, ifMain.BUSY};
            1:       return {ifFast.RN_N, ifFast.SN_N, ifFast.CKEN, ifFast.ACK, ifFast.BUSY};
            default: return {ifSlow.RN_N, ifSlow.SN_N, ifSlow.CKEN, ifSlow.ACK, ifSlow.BUSY};
        endcase
    endfunction

    function automatic logic [16:0] expectedOf(input int n);
        logic [NB-1:0] rn   = '1;
        logic [NB-1:0] sn   = '1;
        logic [NB-1:0] ck   = '1;
        logic [NB-1:0] ack  = '0;
        logic          busy = 1'b0;
        int            k;
        if (mAct[n]) begin
            k    = edgeNo - mStart[n];
            busy = 1'b1;
            if (k < pwA[n]) begin
                if (mOp[n]) sn[mBank[n]] = 1'b0;
                else        rn[mBank[n]] = 1'b0;
            end
            if (k < pwA[n] + recA[n])  ck[mBank[n]]  = 1'b0;
            if (k == pwA[n] + recA[n]) ack[mBank[n]] = 1'b1;
        end
        return {rn, sn, ck, ack, busy};
    endfunction

    task automatic modelReset();
        for (int n = 0; n < 3; n++) begin
            mAct[n] = 1'b0;
            mPtr[n] = NB - 1;
        end
    endtask

    task automatic modelEdge(input int n);
        if (mAct[n] && (edgeNo - mStart[n] == pwA[n] + recA[n] + 1)) begin
            mAct[n] = 1'b0;
        end else if (!mAct[n] && reqV[n] != '0) begin
            for (int i = 1; i <= NB; i++) begin
                int b = (mPtr[n] + i) % NB;
                if (reqV[n][b]) begin
                    mAct[n]   = 1'b1;
                    mBank[n]  = b;
                    mOp[n]    = opV[n][b];
                    mStart[n] = edgeNo;
                    mPtr[n]   = b;
                    break;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [16:0]   act;
        logic [16:0]   exp;
        logic [NB-1:0] low;
        for (int n = 0; n < 3; n++) begin
            act = actualOf(n);
            exp = expectedOf(n);
            checks++;
            assert (act === exp) else begin
                failures++;
                $error("[TB] FAIL %s inst%0d edge%0d: observed %h expected %h", tag, n, edgeNo, act, exp);
            end
        end
        low = ~ifMain.RN_N | ~ifMain.SN_N | ~ifMain.CKEN;
        checks++;
        assert ($countones(low) <= 1) else begin
            failures++;
            $error("[TB] FAIL %s one_bank edge%0d: observed low mask %b expected at most one bit", tag, edgeNo, low);
        end
        checks++;
        assert ((~ifMain.RN_N & ~ifMain.SN_N) === 4'b0000) else begin
            failures++;
            $error("[TB] FAIL %s rn_sn_overlap edge%0d: observed %b expected 0000", tag, edgeNo, ~ifMain.RN_N & ~ifMain.SN_N);
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input int n, input logic [NB-1:0] req, input logic [NB-1:0] op);
        reqV[n] = req;
        opV[n]  = op;
    endtask

    task automatic step(input string tag);
        @(posedge CK);
        edgeNo++;
        for (int n = 0; n < 3; n++) modelEdge(n);
        #1;
        checkOutput(tag);
    endtask

    // Asserted mid-cycle; outputs must already be at reset values before the next edge.
    task automatic doReset(input string tag);
        #2 RST = 1'b1;
        #1;
        modelReset();
        checkOutput(tag);
        #1 RST = 1'b0;
    endtask

    task automatic runSeq(input int n, input string tag, output int steps, output int lowCyc, output int ackBank);
        logic [16:0] a;
        steps   = 0;
        lowCyc  = 0;
        ackBank = -1;
        for (int i = 0; i < 40; i++) begin
            step(tag);
            steps++;
            a = actualOf(n);
            if ((~a[16:13] | ~a[12:9]) != '0) lowCyc++;
            if (a[4:1] != '0) begin
                for (int b = 0; b < NB; b++) if (a[1 + b]) ackBank = b;
                break;
            end
        end
    endtask

    initial begin
        int s, l, b;
        int rrOrder [2] = '{1, 3};

        RST = 1'b1;
        for (int n = 0; n < 3; n++) applyStimulus(n, '0, '0);
        #3;
        modelReset();
        checkOutput("reset_init");
        #4 RST = 1'b0;

        $display("[TB] single clear on bank 2");
        applyStimulus(0, 4'b0100, 4'b0000);
        runSeq(0, "clear", s, l, b);
        checkValue("clear_ack_bank", 32'(b), 32'd2);
        checkValue("clear_latency", 32'(s), 32'd5);
        checkValue("clear_pulse_len", 32'(l), 32'd2);
        applyStimulus(0, 4'b0000, 4'b0000);
        step("clear_done");

        $display("[TB] preset on bank 0 with OP flipped mid-pulse");
        applyStimulus(0, 4'b0001, 4'b0001);
        step("preset_grant");
        checkValue("preset_sn", 32'(ifMain.SN_N), 32'hE);
        checkValue("preset_rn", 32'(ifMain.RN_N), 32'hF);
        applyStimulus(0, 4'b0001, 4'b0000);
        runSeq(0, "preset", s, l, b);
        checkValue("preset_ack_bank", 32'(b), 32'd0);
        checkValue("preset_latency", 32'(s), 32'd4);
        checkValue("preset_pulse_rest", 32'(l), 32'd1);
        applyStimulus(0, 4'b0000, 4'b0000);
        step("preset_done");

        $display("[TB] round robin from reset");
        doReset("rst_idle");
        applyStimulus(0, 4'hF, 4'($urandom));
        for (int i = 0; i < 4; i++) begin
            runSeq(0, "rr_all", s, l, b);
            checkValue("rr_order", 32'(b), 32'(i));
            checkValue("rr_latency", 32'(s), 32'd5);
            if (b >= 0) reqV[0][b] = 1'b0;
            step("rr_gap");
            checkValue("rr_gap_busy", 32'(ifMain.BUSY), 32'd0);
        end
        applyStimulus(0, 4'b1010, 4'($urandom));
        for (int i = 0; i < 2; i++) begin
            runSeq(0, "rr_pair", s, l, b);
            checkValue("rr_pair_order", 32'(b), 32'(rrOrder[i]));
            checkValue("rr_pair_latency", 32'(s), 32'd5);
            if (b >= 0) reqV[0][b] = 1'b0;
            step("rr_pair_gap");
        end

        $display("[TB] reset during pulse on bank 1");
        applyStimulus(0, 4'b0010, 4'b0000);
        step("mid_grant");
        step("mid_pulse");
        doReset("mid_rst");
        checkValue("mid_rn1", 32'(ifMain.RN_N[1]), 32'd1);
        checkValue("mid_cken1", 32'(ifMain.CKEN[1]), 32'd1);
        runSeq(0, "mid_reserve", s, l, b);
        checkValue("mid_ack_bank", 32'(b), 32'd1);
        checkValue("mid_latency", 32'(s), 32'd5);
        checkValue("mid_pulse_len", 32'(l), 32'd2);
        applyStimulus(0, 4'b0000, 4'b0000);
        step("mid_done");

        $display("[TB] REQ dropped during recovery");
        applyStimulus(0, 4'b1000, 4'b0000);
        step("drop_grant");
        step("drop_pulse");
        step("drop_recov");
        applyStimulus(0, 4'b0000, 4'b0000);
        runSeq(0, "drop", s, l, b);
        checkValue("drop_ack_bank", 32'(b), 32'd3);
        checkValue("drop_latency", 32'(s), 32'd2);
        step("drop_done");

        $display("[TB] PW=1 REC=1 and PW=5 REC=3 instances");
        applyStimulus(1, 4'b0100, 4'b0000);
        runSeq(1, "fast", s, l, b);
        checkValue("fast_ack_bank", 32'(b), 32'd2);
        checkValue("fast_latency", 32'(s), 32'd3);
        checkValue("fast_pulse_len", 32'(l), 32'd1);
        applyStimulus(1, 4'b0000, 4'b0000);
        step("fast_done");
        applyStimulus(2, 4'b0100, 4'b0000);
        runSeq(2, "slow", s, l, b);
        checkValue("slow_ack_bank", 32'(b), 32'd2);
        checkValue("slow_latency", 32'(s), 32'd9);
        checkValue("slow_pulse_len", 32'(l), 32'd5);
        applyStimulus(2, 4'b0000, 4'b0000);
        step("slow_done");

        $display("[TB] randomized requests");
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 3; n++) applyStimulus(n, 4'($urandom) & 4'($urandom), 4'($urandom));
            if (i == 200) doReset("rand_rst");
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
